// File: rtl/bias_bram_stream_if.sv
// Valid/ready stream carrying bias words from the bias buffer to the compute core.
interface bias_bram_stream_if #(
    parameter int DATA_W = 40
) ();
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              ready;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/bias_bram_stream.sv
// Bias buffer: host-loaded BRAM plus per-layer descriptors, streamed per layer through a FWFT FIFO.
// Define BIAS_RD_REG_EN to add a BRAM output register (read latency 2 instead of 1).
module bias_bram_stream #(
    parameter int  DATA_W     = 40,
    parameter int  DEPTH      = 64,
    parameter int  NUM_LAYERS = 8,
    parameter int  FIFO_DEPTH = 8,
    localparam int ADDR_W     = $clog2(DEPTH),
    localparam int LAYER_W    = $clog2(NUM_LAYERS),
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_W-1:0]    wr_data,
    input  logic                 cfg_we,
    input  logic [LAYER_W-1:0]   cfg_layer,
    input  logic [ADDR_W-1:0]    cfg_base,
    input  logic [ADDR_W:0]      cfg_len,
    input  logic                 layer_start,
    input  logic [LAYER_W-1:0]   layer_id,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    bias_bram_stream_if.master   m,
    output logic [LVL_W-1:0]     fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LEN_W = ADDR_W + 1;
    localparam int CW    = LVL_W + 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_DRAIN, S_DONE} state_t;

    logic [DATA_W-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0]  base_tab [NUM_LAYERS];
    logic [LEN_W-1:0]   len_tab [NUM_LAYERS];

    state_t             state;
    logic [ADDR_W-1:0]  rd_addr;
    logic [ADDR_W-1:0]  rd_addr_nxt;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   issued;
    logic [LEN_W-1:0]   issued_nxt;
    logic               rd_en;
    logic               drain_ok;

    logic [DATA_W-1:0]  rd_data_p0;
    logic               vld_p0;
`ifdef BIAS_RD_REG_EN
    logic [DATA_W-1:0]  rd_data_p1;
    logic               vld_p1;
`endif

    logic               push;
    logic               pop;
    logic [DATA_W-1:0]  push_data;
    logic [1:0]         inflight;
    logic [CW-1:0]      credit_sum;

    logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    always_comb begin
`ifdef BIAS_RD_REG_EN
        push      = vld_p1;
        push_data = rd_data_p1;
        inflight  = {1'b0, vld_p0} + {1'b0, vld_p1};
`else
        push      = vld_p0;
        push_data = rd_data_p0;
        inflight  = {1'b0, vld_p0};
`endif
        pop         = (fifo_level != '0) && m.ready;
        // Reads still in the pipe reserve FIFO slots so the FIFO can never overflow.
        credit_sum  = CW'(fifo_level) + CW'(inflight);
        rd_en       = (state == S_FETCH) && (credit_sum < CW'(FIFO_DEPTH));
        rd_addr_nxt = (rd_addr == ADDR_W'(DEPTH - 1)) ? '0 : rd_addr + ADDR_W'(1);
        issued_nxt  = issued + LEN_W'(1);
        drain_ok    = (inflight == '0) &&
                      ((fifo_level == '0) || ((fifo_level == LVL_W'(1)) && pop));
    end

    assign m.valid = (fifo_level != '0);
    assign m.data  = m.valid ? fifo_mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                base_tab[i] <= '0;
                len_tab[i]  <= '0;
            end
        end else if (cfg_we) begin
            base_tab[cfg_layer] <= cfg_base;
            len_tab[cfg_layer]  <= cfg_len;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    // Stage p0: BRAM read, read-first against a same-cycle host write
    always_ff @(posedge clk) begin
        if (rd_en)
            rd_data_p0 <= mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (rst)
            vld_p0 <= 1'b0;
        else
            vld_p0 <= rd_en;
    end

`ifdef BIAS_RD_REG_EN
    // Stage p1: optional BRAM output register
    always_ff @(posedge clk) begin
        rd_data_p1 <= rd_data_p0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= vld_p0;
    end
`endif

    // Output FIFO, first-word-fall-through
    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            issued <= '0;
            len_q  <= '0;
        end else begin
            done <= 1'b0;
            if (layer_start && (state != S_IDLE))
                err <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (layer_start) begin
                        rd_addr <= base_tab[layer_id];
                        len_q   <= len_tab[layer_id];
                        issued  <= '0;
                        busy    <= 1'b1;
                        state   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // Empty layers take one DRAIN cycle so done lands two cycles after start.
                    state <= (len_q == '0) ? S_DRAIN : S_FETCH;
                end
                S_FETCH: begin
                    if (rd_en) begin
                        rd_addr <= rd_addr_nxt;
                        issued  <= issued_nxt;
                        if (issued_nxt == len_q)
                            state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (drain_ok) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bias_bram_stream.sv
// Randomised bench for bias_bram_stream against an array/queue reference model.
module tb_bias_bram_stream;
    localparam int DATA_W     = 40;
    localparam int DEPTH      = 64;
    localparam int NUM_LAYERS = 8;
    localparam int FIFO_DEPTH = 8;
`ifdef BIAS_RD_REG_EN
    localparam int FIRST_V = 4;
`else
    localparam int FIRST_V = 3;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [5:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              cfg_we;
    logic [2:0]        cfg_layer;
    logic [5:0]        cfg_base;
    logic [6:0]        cfg_len;
    logic              layer_start;
    logic [2:0]        layer_id;
    logic              busy;
    logic              done;
    logic              err;
    logic [3:0]        fifo_level;

    bias_bram_stream_if #(.DATA_W(DATA_W)) m_if ();

    bias_bram_stream #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .NUM_LAYERS(NUM_LAYERS), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_base(cfg_base), .cfg_len(cfg_len),
        .layer_start(layer_start), .layer_id(layer_id),
        .busy(busy), .done(done), .err(err),
        .m(m_if), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [DATA_W-1:0] mem_m [DEPTH];
    int base_m [NUM_LAYERS];
    int len_m  [NUM_LAYERS];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input int a, input logic [DATA_W-1:0] d);
        wr_en = 1'b1; wr_addr = 6'(a); wr_data = d;
        tick();
        wr_en = 1'b0;
        mem_m[a] = d;
    endtask

    task automatic cfg_write(input int l, input int b, input int n);
        cfg_we = 1'b1; cfg_layer = 3'(l); cfg_base = 6'(b); cfg_len = 7'(n);
        tick();
        cfg_we = 1'b0;
        base_m[l] = b;
        len_m[l]  = n;
    endtask

    task automatic clear_tables();
        for (int i = 0; i < NUM_LAYERS; i++) begin
            base_m[i] = 0;
            len_m[i]  = 0;
        end
    endtask

    // mode 0: ready held high, 1: random ready, 2: ready low for 'hold' cycles then high.
    // inj_start: cycle to pulse a stray layer_start (-1 none, -2 in the done cycle).
    task automatic run_stream(input int id, input int mode, input int hold, input int inj_start,
                              input int wr_cyc, input int wa, input logic [DATA_W-1:0] wd,
                              input int exp_max_level);
        logic [DATA_W-1:0] exp_q[$];
        int n, cyc, first_v, last_hs, done_cnt, max_lvl;
        bit done_seen, finished;
        n = len_m[id];
        for (int i = 0; i < n; i++)
            exp_q.push_back(mem_m[(base_m[id] + i) % DEPTH]);
        layer_start = 1'b1; layer_id = 3'(id);
        tick();
        layer_start = 1'b0;
        chk("busy_after_start", busy, 1);
        cyc = 0; first_v = -1; last_hs = -1; done_cnt = 0; max_lvl = 0;
        done_seen = 0; finished = 0;
        while (!finished && cyc < 600) begin
            if (m_if.valid && first_v < 0)
                first_v = cyc;
            if (int'(fifo_level) > max_lvl)
                max_lvl = int'(fifo_level);
            if (!m_if.valid)
                chk("data_zero_when_empty", m_if.data, 0);
            if (done_seen && !done) begin
                chk("busy_after_done", busy, 0);
                finished = 1;
            end else begin
                if (done) begin
                    done_cnt++;
                    done_seen = 1;
                    chk("done_time", cyc, (n == 0) ? 2 : last_hs + 1);
                    if (inj_start == -2) begin
                        layer_start = 1'b1; layer_id = 3'((id + 1) % NUM_LAYERS);
                    end
                end
                case (mode)
                    0:       m_if.ready = 1'b1;
                    1:       m_if.ready = 1'($urandom_range(0, 1));
                    default: m_if.ready = (cyc >= hold);
                endcase
                if (cyc == inj_start) begin
                    layer_start = 1'b1; layer_id = 3'((id + 1) % NUM_LAYERS);
                end
                if (cyc == wr_cyc) begin
                    wr_en = 1'b1; wr_addr = 6'(wa); wr_data = wd;
                end
                if (m_if.valid && m_if.ready) begin
                    if (exp_q.size() == 0)
                        chk("extra_word", 1, 0);
                    else
                        chk("word", m_if.data, exp_q.pop_front());
                    last_hs = cyc;
                end
                tick();
                cyc++;
                layer_start = 1'b0;
                wr_en = 1'b0;
            end
        end
        if (!finished)
            chk("stream_timeout", 0, 1);
        chk("words_left", exp_q.size(), 0);
        chk("done_count", done_cnt, 1);
        chk("first_valid", first_v, (n == 0) ? -1 : FIRST_V);
        chk("level_bound", max_lvl <= FIFO_DEPTH, 1);
        if (exp_max_level >= 0)
            chk("max_level", max_lvl, exp_max_level);
        if (wr_cyc >= 0)
            mem_m[wa] = wd;
        m_if.ready = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        cfg_we = 1'b0; cfg_layer = '0; cfg_base = '0; cfg_len = '0;
        layer_start = 1'b0; layer_id = '0; m_if.ready = 1'b0;
        clear_tables();
        tick(); tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_valid", m_if.valid, 0);
        chk("rst_data", m_if.data, 0);
        chk("rst_level", fifo_level, 0);

        for (int i = 0; i < DEPTH; i++)
            host_write(i, DATA_W'(i + 100));

        cfg_write(2, 10, 5);
        run_stream(2, 0, 0, -1, -1, 0, '0, -1);
        chk("err_clean", err, 0);

        cfg_write(1, 62, 4);
        run_stream(1, 0, 0, -1, -1, 0, '0, -1);

        cfg_write(5, 0, 20);
        run_stream(5, 2, 30, -1, -1, 0, '0, FIFO_DEPTH);

        cfg_write(3, 7, 0);
        run_stream(3, 0, 0, -1, -1, 0, '0, 0);

        // Write addr 12 on the edge its read is issued: old value must stream out.
        run_stream(2, 0, 0, -1, 3, 12, 40'hAB_CDEF_0123, -1);
        run_stream(2, 1, 0, -1, -1, 0, '0, -1);

        run_stream(5, 1, 0, 4, -1, 0, '0, -1);
        chk("err_after_busy_start", err, 1);
        run_stream(1, 1, 0, -1, -1, 0, '0, -1);
        chk("err_sticky", err, 1);

        rst = 1'b1; tick(); rst = 1'b0; clear_tables();
        chk("err_cleared_by_rst", err, 0);
        cfg_write(2, 10, 5);
        run_stream(2, 0, 0, -2, -1, 0, '0, -1);
        chk("err_start_in_done", err, 1);

        cfg_write(4, 0, 20);
        layer_start = 1'b1; layer_id = 3'd4; m_if.ready = 1'b1;
        tick();
        layer_start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1; tick(); rst = 1'b0; clear_tables();
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_err", err, 0);
        chk("abort_valid", m_if.valid, 0);
        chk("abort_data", m_if.data, 0);
        chk("abort_level", fifo_level, 0);
        m_if.ready = 1'b0;
        tick(); tick();
        chk("abort_no_late_valid", m_if.valid, 0);
        run_stream(4, 0, 0, -1, -1, 0, '0, 0);

        for (int it = 0; it < 12; it++) begin
            int l;
            for (int k = 0; k < 3; k++)
                host_write($urandom_range(0, DEPTH - 1), {8'($urandom), 32'($urandom)});
            l = $urandom_range(0, NUM_LAYERS - 1);
            cfg_write(l, $urandom_range(0, DEPTH - 1), $urandom_range(0, 30));
            run_stream(l, 1, 0, -1, -1, 0, '0, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
